agent_arbiter: RTL and testbench
================================

# agent_arbiter

Parameterized N-agent round-robin arbiter with a registered one-hot grant and no preemption. It sits between N requesting agents and one shared resource. A grant stays with its owner until that owner drops its request. The block is the RTL implementation behind the `arb_if` interface; each agent's modport view carries its own `req[i]` and `gnt[i]` bit.

## Interface
- `num_agents`, default 1, number of requesting agents (legal range 1..32).
- `clk`  input  1  rising-edge clock, the only clock.
- `reset`  input  1  synchronous reset, active-low (0 = reset), sampled on `clk` rising edge.
- `req`  input  num_agents  per-agent request level; bit i belongs to agent i.
- `gnt`  output  num_agents  registered per-agent grant; one-hot or all-zero.
- `gnt_valid`  output  1  registered; equals `|gnt`.
- `gnt_id`  output  max(1,$clog2(num_agents))  registered; index of the granted agent, 0 when `gnt_valid`=0.

## Operation
- Internal state:
  - `owner`: the current grant index plus a valid flag.
  - `ptr`: the round-robin priority pointer, range 0..num_agents-1.
- Reset (`reset`=0 at an edge):
  - `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `ptr`=0.
  - Reset has priority over all other activity, including mid-grant.
- Each non-reset edge, in priority order:
  1. **Hold:** if an owner exists and `req[owner]`=1, keep `gnt` unchanged and leave `ptr` unchanged.
  2. **Arbitrate:** otherwise, scan `req` starting at index `ptr`, then `ptr+1`, wrapping modulo num_agents. Grant the first set bit i: `gnt`=1<<i, `gnt_id`=i, `ptr`=(i+1) mod num_agents.
  3. **Idle:** if no request is set, `gnt`=0, `gnt_id`=0, `gnt_valid`=0, and `ptr` is unchanged.
- When an owner releases and another agent requests, the handover happens on the same edge with zero idle cycles. The releasing agent is excluded only by the pointer order: it is last in the new scan order.
- A request that appears on the same edge as an owner's release competes under the pointer order. It gets no special priority.
- `gnt` never has more than one bit set, in any cycle.
- A grant is never issued to an agent whose `req` was 0 at the deciding edge.
- num_agents=1:
  - `gnt[0]` is a registered copy of `req[0]`.
  - `gnt_id` is always 0.
  - `ptr` is a constant 0.
- Modport contract (informational):
  - Arbiter side drives `gnt` and reads `req`, `clk`, `reset`.
  - Agent side drives `req[i]` and reads `gnt[i]`, `clk`, `reset`.
- `req` bits are level-sensitive. An agent must keep `req[i]` high until it sees `gnt[i]`.

## Timing
- Latency is 1 cycle:
  - `req` sampled at edge n produces `gnt` valid after edge n.
  - When an agent drops its request before edge n, `gnt` falls after edge n.
- All outputs are flops with no combinational path from `req` to `gnt`. `gnt`, `gnt_valid` and `gnt_id` always change on the same edge.
- Starvation bound: with all agents requesting, an agent waits at most num_agents-1 ownership periods.
- Deassertion of `reset` takes effect at the first edge that samples `reset`=1; arbitration starts on that edge.

## Test plan
- **Reset:**
  - Stimulus: num_agents=4, `req`=4'b1111 while `reset`=0 for 3 edges.
  - Required: `gnt`=0, `gnt_valid`=0, `gnt_id`=0 throughout.
  - Stimulus: release reset.
  - Required: after the first edge `gnt`=4'b0001, `gnt_id`=0.
- **Hold and rotation:**
  - Stimulus: `req`=4'b1111, then drop `req[0]` for one cycle.
  - Required: `gnt` moves 0001→0010 at that edge, then stays 0010 while `req[1]`=1.
  - Stimulus: repeat the drop for the current owner each time.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001.
- **Pointer skip:**
  - Stimulus: after agent 1 owns and releases, `req`=4'b0011.
  - Required: grant goes to agent 0 (scan 2,3,0), `gnt_id`=0.
- **Idle and latency:**
  - Stimulus: `req`=0 for 2 edges, then `req`=4'b0100 set before edge n.
  - Required: `gnt`=0 until edge n, then `gnt`=4'b0100, `gnt_valid`=1.
- **Reset mid-grant:**
  - Stimulus: agent 2 owns with `req`=4'b0100 held; assert `reset`=0 for 1 edge.
  - Required: `gnt`=0 after that edge.
  - Stimulus: release reset with `req`=4'b0101.
  - Required: agent 0 is granted (`ptr` reset to 0).
- **Single agent:**
  - Stimulus: num_agents=1, toggle `req[0]` with pattern 1,1,0,1.
  - Required: `gnt[0]` shows 1,1,0,1, delayed by one edge; `gnt_id` is always 0.

Source files
------------

// File: rtl/agent_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : agent_arbiter
// Brief    : N-agent round-robin arbiter, registered one-hot grant, no preemption.
// Revision : 1.0
// ============================================================================
module agent_arbiter #(
    parameter int num_agents = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [num_agents-1:0]                 req,
    output logic [num_agents-1:0]                 gnt,
    output logic                                  gnt_valid,
    output logic [((num_agents > 1) ? $clog2(num_agents) : 1)-1:0] gnt_id
);

    localparam int c_ID_W = (num_agents > 1) ? $clog2(num_agents) : 1;

    if (num_agents == 1) begin : g_single
        logic r_gnt;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_gnt <= 1'b0;
            end else begin
                r_gnt <= req[0];
            end
        end

        assign gnt       = r_gnt;
        assign gnt_valid = r_gnt;
        assign gnt_id    = '0;
    end else begin : g_multi
        logic [num_agents-1:0] r_gnt;
        logic [c_ID_W-1:0]     r_id;
        logic                  r_valid;
        logic [c_ID_W-1:0]     r_ptr;

        logic [num_agents-1:0] w_gnt_nxt;
        logic [c_ID_W-1:0]     w_id_nxt;
        logic                  w_valid_nxt;
        logic [c_ID_W-1:0]     w_ptr_nxt;
        logic                  w_found;
        logic [c_ID_W-1:0]     w_pick;
        logic [c_ID_W:0]       w_cand;

        // Round-robin scan: first requester at or after the pointer, wrapping.
        always_comb begin
            w_found = 1'b0;
            w_pick  = '0;
            w_cand  = '0;
            for (int k = 0; k < num_agents; k++) begin
                w_cand = {1'b0, r_ptr} + (c_ID_W+1)'(k);
                if (w_cand >= (c_ID_W+1)'(num_agents)) begin
                    w_cand = w_cand - (c_ID_W+1)'(num_agents);
                end
                if (!w_found && req[w_cand[c_ID_W-1:0]]) begin
                    w_found = 1'b1;
                    w_pick  = w_cand[c_ID_W-1:0];
                end
            end
        end

        always_comb begin
            w_gnt_nxt   = '0;
            w_id_nxt    = '0;
            w_valid_nxt = 1'b0;
            w_ptr_nxt   = r_ptr;
            if (r_valid && req[r_id]) begin
                // Owner keeps the grant for as long as it keeps requesting.
                w_gnt_nxt   = r_gnt;
                w_id_nxt    = r_id;
                w_valid_nxt = 1'b1;
            end else if (w_found) begin
                w_gnt_nxt   = {{(num_agents-1){1'b0}}, 1'b1} << w_pick;
                w_id_nxt    = w_pick;
                w_valid_nxt = 1'b1;
                w_ptr_nxt   = (w_pick == c_ID_W'(num_agents-1)) ? '0 : w_pick + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_gnt   <= '0;
                r_id    <= '0;
                r_valid <= 1'b0;
                r_ptr   <= '0;
            end else begin
                r_gnt   <= w_gnt_nxt;
                r_id    <= w_id_nxt;
                r_valid <= w_valid_nxt;
                r_ptr   <= w_ptr_nxt;
            end
        end

        assign gnt       = r_gnt;
        assign gnt_valid = r_valid;
        assign gnt_id    = r_id;
    end

endmodule
`default_nettype wire

// File: tb/tb_agent_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_agent_arbiter
// Brief    : Scoreboard bench for agent_arbiter with 4-agent and 1-agent instances.
// Revision : 1.0
// ============================================================================
module tb_agent_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req4;
    logic [3:0] gnt4;
    logic       gnt_valid4;
    logic [1:0] gnt_id4;
    logic [0:0] req1;
    logic [0:0] gnt1;
    logic       gnt_valid1;
    logic [0:0] gnt_id1;

    int checks   = 0;
    int failures = 0;

    logic [6:0] q4[$];  // {gnt, valid, id}
    logic [2:0] q1[$];  // {gnt, valid, id}

    // Reference model state for the 4-agent instance.
    logic [3:0] m_gnt;
    logic       m_val;
    logic [1:0] m_id;
    int         m_ptr;

    agent_arbiter #(.num_agents(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .req       (req4),
        .gnt       (gnt4),
        .gnt_valid (gnt_valid4),
        .gnt_id    (gnt_id4)
    );

    agent_arbiter #(.num_agents(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .req       (req1),
        .gnt       (gnt1),
        .gnt_valid (gnt_valid1),
        .gnt_id    (gnt_id1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic [3:0] r);
        bit found;
        int idx;
        if (!rst_n) begin
            m_gnt = 4'b0; m_val = 1'b0; m_id = 2'd0; m_ptr = 0;
        end else if (m_val && r[m_id]) begin
            // hold: nothing changes
        end else begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (!found && r[idx]) begin
                    found = 1;
                    m_gnt = 4'b0;
                    m_gnt[idx] = 1'b1;
                    m_id  = idx[1:0];
                    m_val = 1'b1;
                    m_ptr = (idx + 1) % 4;
                end
            end
            if (!found) begin
                m_gnt = 4'b0; m_val = 1'b0; m_id = 2'd0;
            end
        end
    endtask

    // Drive one cycle of stimulus, push expectations, then compare after the edge.
    task automatic step(input logic rst_n, input logic [3:0] r4, input logic r1);
        logic [6:0] e4;
        logic [2:0] e1;
        @(negedge clk);
        reset = rst_n;
        req4  = r4;
        req1  = r1;
        model_edge(rst_n, r4);
        q4.push_back({m_gnt, m_val, m_id});
        q1.push_back({rst_n & r1, rst_n & r1, 1'b0});
        @(posedge clk);
        #1;
        if (q4.size() == 0 || q1.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            e4 = q4.pop_front();
            e1 = q1.pop_front();
            check("gnt4",    {28'd0, gnt4},       {28'd0, e4[6:3]});
            check("valid4",  {31'd0, gnt_valid4}, {31'd0, e4[2]});
            check("id4",     {30'd0, gnt_id4},    {30'd0, e4[1:0]});
            check("onehot4", {31'd0, ($countones(gnt4) <= 1)}, 32'd1);
            check("gnt1",    {31'd0, gnt1},       {31'd0, e1[2]});
            check("valid1",  {31'd0, gnt_valid1}, {31'd0, e1[1]});
            check("id1",     {31'd0, gnt_id1},    {31'd0, e1[0]});
        end
    endtask

    initial begin
        logic [3:0] rr;
        reset = 1'b0;
        req4  = 4'b0;
        req1  = 1'b0;
        m_gnt = 4'b0; m_val = 1'b0; m_id = 2'd0; m_ptr = 0;

        // Reset held with all requesting
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b1111, 1'b1);
            check("rst_gnt", {28'd0, gnt4}, 32'd0);
        end

        // Release reset; single agent pattern 1,1,0,1 runs alongside
        step(1'b1, 4'b1111, 1'b1);
        check("first_gnt", {28'd0, gnt4}, 32'h1);
        check("first_gnt1", {31'd0, gnt1}, 32'd1);
        step(1'b1, 4'b1111, 1'b1);
        check("hold0", {28'd0, gnt4}, 32'h1);
        step(1'b1, 4'b1110, 1'b0);
        check("rot1", {28'd0, gnt4}, 32'h2);
        check("pat_gnt1_0", {31'd0, gnt1}, 32'd0);
        step(1'b1, 4'b1111, 1'b1);
        check("hold1", {28'd0, gnt4}, 32'h2);
        step(1'b1, 4'b1101, 1'b0);
        check("rot2", {28'd0, gnt4}, 32'h4);
        step(1'b1, 4'b1011, 1'b1);
        check("rot3", {28'd0, gnt4}, 32'h8);
        step(1'b1, 4'b0111, 1'b0);
        check("rot0", {28'd0, gnt4}, 32'h1);

        // Pointer skip: agent 1 owns, releases, then 0011 scans 2,3,0
        step(1'b1, 4'b0010, 1'b1);
        check("own1", {28'd0, gnt4}, 32'h2);
        step(1'b1, 4'b0000, 1'b0);
        check("idle_rel", {31'd0, gnt_valid4}, 32'd0);
        step(1'b1, 4'b0011, 1'b1);
        check("skip_gnt", {28'd0, gnt4}, 32'h1);
        check("skip_id", {30'd0, gnt_id4}, 32'd0);

        // Idle then latency
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        check("idle_gnt", {28'd0, gnt4}, 32'd0);
        step(1'b1, 4'b0100, 1'b1);
        check("lat_gnt", {28'd0, gnt4}, 32'h4);
        check("lat_valid", {31'd0, gnt_valid4}, 32'd1);
        check("lat_id", {30'd0, gnt_id4}, 32'd2);

        // Reset mid-grant, then pointer back at 0
        step(1'b1, 4'b0100, 1'b1);
        step(1'b0, 4'b0100, 1'b1);
        check("midrst_gnt", {28'd0, gnt4}, 32'd0);
        step(1'b1, 4'b0101, 1'b1);
        check("post_rst", {28'd0, gnt4}, 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 60; i++) begin
            rr = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 19) != 0), rr, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
